// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: one owner at a time, held until release, owner drop or hold timeout.
// Define PRIO_ARBITER_RR_EN for round-robin selection; the default build is fixed priority (lowest index wins).
module prio_arbiter #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam bit          TO_EN    = (MAX_HOLD > 0);
  localparam [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_vld_q, gnt_vld_d;
  logic               timeout_q, timeout_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_rel;
  logic               hold_expired;

`ifdef PRIO_ARBITER_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  // Search begins at ptr and wraps, so the requester just served drops to lowest priority.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win_found) begin
      if (int'(win_idx) == N - 1) ptr_d = '0;
      else                        ptr_d = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`endif

  assign owner_rel    = rel || !req[gnt_idx_q];
  assign hold_expired = TO_EN && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d            = S_BUSY;
          gnt_d              = '0;
          gnt_d[win_idx]     = 1'b1;
          gnt_idx_d          = win_idx;
          gnt_vld_d          = 1'b1;
          hold_d             = '0;
        end
      end
      S_BUSY: begin
        // A genuine release wins over a coincident timeout, so no pulse then.
        if (owner_rel || hold_expired) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          gnt_vld_d = 1'b0;
          hold_d    = '0;
          timeout_d = !owner_rel;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule
